md5_stream_core: RTL

//  Multi-block MD5 engine: absorbs a stream of pre-padded 512-bit blocks over valid/ready, chains
//  the state across blocks and emits the 128-bit digest after the block flagged last.

---
 rtl/md5_stream_core.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/md5_stream_core.sv
// md5_stream_core: multi-block MD5 engine. Accepts pre-padded 512-bit blocks
// over valid/ready and chains the state across the blocks of a message. After
// the block flagged last it emits the 128-bit digest. ROUNDS_PER_CYCLE MD5
// steps are evaluated combinationally per clock.
`timescale 1ns/1ps

module md5_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit OUT_HOLD         = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic         in_last,
  input  logic [511:0] data_in,
  output logic [127:0] hash,
  output logic         hash_valid,
  input  logic         hash_ready,
  output logic         busy
);

  // Only divisors of 64 up to 16 keep the step counter landing exactly on 63.
  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rounds
    $error("md5_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUND = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  localparam logic [5:0] STEP_INC  = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] STEP_LAST = 6'(64 - ROUNDS_PER_CYCLE);

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_ROM [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Byte reversal: MD5 works on little-endian words, the bus is big-endian bytes.
  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  // Per-step shift amount: four per round, repeating every four steps.
  function automatic logic [4:0] s_rom(input logic [5:0] i);
    logic [4:0] s;
    case ({i[5:4], i[1:0]})
      4'd0:  s = 5'd7;
      4'd1:  s = 5'd12;
      4'd2:  s = 5'd17;
      4'd3:  s = 5'd22;
      4'd4:  s = 5'd5;
      4'd5:  s = 5'd9;
      4'd6:  s = 5'd14;
      4'd7:  s = 5'd20;
      4'd8:  s = 5'd4;
      4'd9:  s = 5'd11;
      4'd10: s = 5'd16;
      4'd11: s = 5'd23;
      4'd12: s = 5'd6;
      4'd13: s = 5'd10;
      4'd14: s = 5'd15;
      default: s = 5'd21;
    endcase
    return s;
  endfunction

  // One MD5 step on packed {a,b,c,d}; returns the rotated state {d, b', b, c}.
  function automatic logic [127:0] md5_step(input logic [127:0]      st,
                                            input logic [5:0]        i,
                                            input logic [15:0][31:0] m);
    logic [31:0] a, b, c, d, f, tmp;
    logic [3:0]  ii, g;
    a  = st[127:96];
    b  = st[95:64];
    c  = st[63:32];
    d  = st[31:0];
    ii = i[3:0];
    case (i[5:4])
      2'd0: begin f = (b & c) | (~b & d); g = ii;                  end
      2'd1: begin f = (b & d) | (c & ~d); g = ii * 4'd5 + 4'd1;    end
      2'd2: begin f = b ^ c ^ d;          g = ii * 4'd3 + 4'd5;    end
      default: begin f = c ^ (b | ~d);    g = ii * 4'd7;           end
    endcase
    tmp = a + f + K_ROM[i] + m[g];
    return {d, b + rotl(tmp, s_rom(i)), b, c};
  endfunction

  logic [1:0]         r_state;
  logic               r_alive;
  logic [5:0]         r_step;
  logic [31:0]        r_a, r_b, r_c, r_d;
  logic [31:0]        r_ca, r_cb, r_cc, r_cd;
  logic               r_first, r_last;
  logic [127:0]       r_hash;
  logic               r_hash_valid;
  logic [15:0][31:0]  r_m;

  logic               w_accept;
  logic [127:0]       w_work;
  logic [31:0]        w_base_a, w_base_b, w_base_c, w_base_d;
  logic [31:0]        w_sum_a, w_sum_b, w_sum_c, w_sum_d;

  assign in_ready   = r_alive && (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign hash       = r_hash;
  assign hash_valid = r_hash_valid;
  assign w_accept   = in_valid && in_ready;

  // Chain ROUNDS_PER_CYCLE steps combinationally starting from the working regs.
  always_comb begin
    // NOTE: blocking assignments here are deliberate -- each loop pass must see
    // the state produced by the previous step within the same evaluation.
    w_work = {r_a, r_b, r_c, r_d};
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      w_work = md5_step(w_work, r_step + 6'(k), r_m);
    end
  end

  // Block-end feed-forward: add the working vars onto the chaining value.
  always_comb begin
    w_base_a = r_first ? IV_A : r_ca;
    w_base_b = r_first ? IV_B : r_cb;
    w_base_c = r_first ? IV_C : r_cc;
    w_base_d = r_first ? IV_D : r_cd;
    w_sum_a  = w_base_a + r_a;
    w_sum_b  = w_base_b + r_b;
    w_sum_c  = w_base_c + r_c;
    w_sum_d  = w_base_d + r_d;
  end

  // Message words latched on acceptance, stored little-endian.
  // NOTE: no reset on this 512-bit store -- it is always written before being
  // read, so a reset would only add fan-out to the reset tree.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < 16; i++) begin
        r_m[i] <= bswap(data_in[511 - 32*i -: 32]);
      end
    end
  end

  // Control FSM, working variables, chaining value and digest output.
  // NOTE: non-blocking assignments throughout so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_alive      <= 1'b0;
      r_step       <= '0;
      r_a          <= IV_A;
      r_b          <= IV_B;
      r_c          <= IV_C;
      r_d          <= IV_D;
      r_ca         <= IV_A;
      r_cb         <= IV_B;
      r_cc         <= IV_C;
      r_cd         <= IV_D;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_hash       <= '0;
      r_hash_valid <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          // Ends the one-cycle pulse when OUT_HOLD=0; already low otherwise.
          r_hash_valid <= 1'b0;
          if (w_accept) begin
            r_a     <= in_first ? IV_A : r_ca;
            r_b     <= in_first ? IV_B : r_cb;
            r_c     <= in_first ? IV_C : r_cc;
            r_d     <= in_first ? IV_D : r_cd;
            r_first <= in_first;
            r_last  <= in_last;
            r_step  <= '0;
            r_state <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          {r_a, r_b, r_c, r_d} <= w_work;
          r_step               <= r_step + STEP_INC;
          if (r_step == STEP_LAST) r_state <= ST_FINAL;
        end
        ST_FINAL: begin
          if (r_last) begin
            r_hash       <= {bswap(w_sum_a), bswap(w_sum_b), bswap(w_sum_c), bswap(w_sum_d)};
            r_hash_valid <= 1'b1;
            r_ca         <= IV_A;
            r_cb         <= IV_B;
            r_cc         <= IV_C;
            r_cd         <= IV_D;
            r_state      <= OUT_HOLD ? ST_OUT : ST_IDLE;
          end else begin
            r_ca    <= w_sum_a;
            r_cb    <= w_sum_b;
            r_cc    <= w_sum_c;
            r_cd    <= w_sum_d;
            r_state <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (hash_ready) begin
            r_hash_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
